// File: rtl/comm_pkg.sv
// Shared constants for the byte-stream communication datapath.
package comm_pkg;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/fifo_shift_store.sv
// Tapped shift-register store: shifts on enable, read tap selects one stage.
module fifo_shift_store
    import comm_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = 4,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    input  logic             tap_en,
    input  logic [IW-1:0]    tap_idx,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (shift_en) begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = tap_en ? stage[tap_idx] : '0;

endmodule

// File: rtl/shift_fifo_ctrl.sv
// Valid/ready byte FIFO; the read tap tracks occupancy so the oldest
// byte is always on out_data.
module shift_fifo_ctrl
    import comm_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    level
);

    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          shift_en;
    logic [IW-1:0] tap_idx;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign level     = count;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // A flushed write must not disturb the store.
    assign shift_en = push & ~flush;
    assign tap_idx  = IW'(count - CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    fifo_shift_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .din      (in_data),
        .tap_en   (out_valid),
        .tap_idx  (tap_idx),
        .dout     (out_data)
    );

endmodule

// File: doc/shift_fifo_ctrl.md
Name: shift_fifo_ctrl

Overview:
Flow-controlled byte FIFO built on a tapped shift-register store. The store shifts only on a push, and the read tap follows occupancy, so the oldest byte is always presented at the output. A valid/ready pair on each side lets a byte-stream producer, such as a serial receiver, feed a consumer, such as a packet parser, in the communication datapath without loss.

Parameters:
WIDTH, 8, data width in bits
DEPTH, 4, number of storage stages; power of two, range 2..16
CW, $clog2(DEPTH+1), width of the occupancy counter (derived, not overridable)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of occupancy
in_data  in  WIDTH  write data
in_valid  in  1  producer has data
in_ready  out  1  FIFO can accept data
out_data  out  WIDTH  oldest stored byte
out_valid  out  1  FIFO is non-empty
out_ready  in  1  consumer takes data
level  out  CW  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous): count=0, all stages=0. Outputs: in_ready=1, out_valid=0, out_data=0, level=0.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready. A full FIFO refuses a write even when a pop happens in the same cycle.
- out_valid = (count != 0).
- level = count.
- Storage on push: stage[0]<=in_data and stage[i]<=stage[i-1]. Storage holds its value when there is no push.
- Read tap: out_data = stage[count-1] when count>0, else 0. The tap mux is combinational from registered state.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged. The store shifts and the tap index stays fixed, so the next-oldest byte is presented in the following cycle.
- Latency: a byte written into an empty FIFO appears on out_data with out_valid=1 in the cycle after the push edge (1 cycle).
- Full (count=DEPTH): in_ready=0. in_valid is ignored and data is not consumed; the producer must hold.
- Empty (count=0): out_valid=0. out_ready is ignored; count never underflows.
- flush: count<=0 on the next edge. Storage contents are left as is. flush takes priority over push and pop in the same cycle, so a simultaneous write is discarded.
- Reset asserted mid-transfer: all state is cleared immediately. After release, the first push behaves as for an empty FIFO.
- Data ordering is strict FIFO. There is no reordering and no duplication.

Decomposition:
- Shared package (comm_pkg): the default data width constant, BYTE_W=8.
- Sub-module fifo_shift_store: WIDTH x DEPTH shift register with shift-enable, asynchronous active-low clear, and a tap index input with combinational mux output.
- The controller holds the counter, handshake logic and flush logic, and drives the store's shift_en and tap index.

Test Plan:
1. Reset, then push 0x11,0x22,0x33 on consecutive cycles with out_ready=0 -> level=3, out_data=0x11, in_ready=1.
2. Push 0xA0..0xA3 to fill, then assert in_valid with 0xFF -> in_ready=0, level stays 4. Drain with out_ready=1 -> outputs A0,A1,A2,A3, then out_valid=0 and level=0.
3. Hold level=2 (0x01,0x02) and apply push 0x03 plus pop every cycle for 6 cycles with incrementing data -> level stays 2 and output order is 01,02,03,04,...
4. With the FIFO empty, assert out_ready=1 for 3 cycles -> level stays 0 and out_valid stays 0.
5. At level=3, assert flush together with push 0x55 -> next cycle level=0, out_valid=0. A subsequent push of 0x66 appears as out_data=0x66.
6. At level=2, drop rst_n low between edges -> level=0, out_valid=0 and out_data=0 immediately, with no clock edge required.
